// File: rtl/vip_matrix_3x3_8bit_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the 3x3 window generator: pixel width, border-mode
// encodings, sync bundle type and a width helper for the position counters.
package vip_matrix_3x3_8bit_pkg;

  localparam int PIX_W            = 8;
  localparam int BORDER_ZERO      = 0;
  localparam int BORDER_REPLICATE = 1;

  typedef logic [PIX_W-1:0] pix_t;

  // Frame sync, line valid and pixel enable travelling together.
  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  // Bits needed to hold 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/vip_matrix_3x3_8bit_row_shift3.sv
`timescale 1ns/1ps
// One window row: three pixel taps that advance by one column per enabled pixel.
// tap3 is the newest pixel, tap1 the oldest.
module vip_win_row_shift3
  import vip_matrix_3x3_8bit_pkg::*;
(
  input  logic clock,
  input  logic rst_n,
  input  logic en,
  input  pix_t din,
  output pix_t tap1,
  output pix_t tap2,
  output pix_t tap3
);

  // Shift one column on each enabled pixel, hold otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tap1 <= '0;
      tap2 <= '0;
      tap3 <= '0;
    end else if (en) begin
      tap3 <= din;
      tap2 <= tap3;
      tap1 <= tap2;
    end
  end

endmodule

// File: rtl/vip_matrix_3x3_8bit.sv
`timescale 1ns/1ps
// 3x3 neighbourhood generator for an 8-bit video stream. The two previous lines
// come from an external line buffer; the current line is delayed locally so all
// three rows line up. Window edges at the top-left of the frame are filled by
// replication or with zeros. Window and post_ syncs lag the input by 2 cycles.
module vip_matrix_3x3_8bit
  import vip_matrix_3x3_8bit_pkg::*;
#(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int BORDER_MODE = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_y,
  output logic             lb_clken,
  output logic             lb_href,
  output logic [PIX_W-1:0] lb_shiftin,
  input  logic [PIX_W-1:0] lb_taps0x,
  input  logic [PIX_W-1:0] lb_taps1x,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [PIX_W-1:0] p11,
  output logic [PIX_W-1:0] p12,
  output logic [PIX_W-1:0] p13,
  output logic [PIX_W-1:0] p21,
  output logic [PIX_W-1:0] p22,
  output logic [PIX_W-1:0] p23,
  output logic [PIX_W-1:0] p31,
  output logic [PIX_W-1:0] p32,
  output logic [PIX_W-1:0] p33
);

  localparam int              COL_W     = clog2(IMG_HDISP);
  localparam int              ROW_W     = clog2(IMG_VDISP);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_HDISP - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_VDISP - 1);
  localparam bit              REPLICATE = (BORDER_MODE == BORDER_REPLICATE);

  sync_t            sync_in;
  sync_t            sync_d1;
  sync_t            sync_d2;
  logic             vsync_d;
  logic             href_d;
  logic             vsync_rise;
  logic             href_fall;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [COL_W-1:0] col_s1;
  logic [ROW_W-1:0] row_s1;
  logic [COL_W-1:0] col_s2;
  logic [ROW_W-1:0] row_s2;
  pix_t             y_d1;
  pix_t             row_din [3];
  pix_t             raw     [3][3];
  pix_t             col_fill[3][3];
  pix_t             win     [3][3];

  // The line buffer is written straight from the input stream.
  assign lb_clken   = per_frame_clken;
  assign lb_href    = per_frame_href;
  assign lb_shiftin = per_img_y;

  assign sync_in    = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};
  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign href_fall  = ~per_frame_href & href_d;

  // Edge history plus column/row position of the pixel currently at the input.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
      if (vsync_rise || !per_frame_href) begin
        col_cnt <= '0;
      end else if (per_frame_clken && (col_cnt != COL_MAX)) begin
        col_cnt <= col_cnt + COL_W'(1);
      end
      if (vsync_rise) begin
        row_cnt <= '0;
      end else if (href_fall && (row_cnt != ROW_MAX)) begin
        row_cnt <= row_cnt + ROW_W'(1);
      end
    end
  end

  // Stage 1: align the current pixel with the line-buffer taps, which arrive a cycle late.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_d1 <= '0;
      y_d1    <= '0;
      col_s1  <= '0;
      row_s1  <= '0;
    end else begin
      sync_d1 <= sync_in;
      y_d1    <= per_img_y;
      col_s1  <= col_cnt;
      row_s1  <= row_cnt;
    end
  end

  // Stage 2: position of the newest window pixel, held between enabled pixels.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_d2 <= '0;
      col_s2  <= '0;
      row_s2  <= '0;
    end else begin
      sync_d2 <= sync_d1;
      if (sync_d1.clken) begin
        col_s2 <= col_s1;
        row_s2 <= row_s1;
      end
    end
  end

  // Row 0 is the oldest line, row 2 the current line.
  assign row_din[0] = lb_taps1x;
  assign row_din[1] = lb_taps0x;
  assign row_din[2] = y_d1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      vip_win_row_shift3 u_row (
        .clock (clock),
        .rst_n (rst_n),
        .en    (sync_d1.clken),
        .din   (row_din[gi]),
        .tap1  (raw[gi][0]),
        .tap2  (raw[gi][1]),
        .tap3  (raw[gi][2])
      );
    end
  endgenerate

  // Column border: near the left edge the stale older columns are replaced.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        col_fill[r][c] = raw[r][c];
      end
      if (col_s2 == '0) begin
        col_fill[r][0] = REPLICATE ? raw[r][2] : '0;
        col_fill[r][1] = REPLICATE ? raw[r][2] : '0;
      end else if (col_s2 == COL_W'(1)) begin
        col_fill[r][0] = REPLICATE ? raw[r][1] : '0;
      end
    end
  end

  // Row border: applied to the column-filled rows so corners come out consistent.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[r][c] = col_fill[r][c];
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (row_s2 == '0) begin
        win[0][c] = REPLICATE ? col_fill[2][c] : '0;
        win[1][c] = REPLICATE ? col_fill[2][c] : '0;
      end else if (row_s2 == ROW_W'(1)) begin
        win[0][c] = REPLICATE ? col_fill[1][c] : '0;
      end
    end
  end

  assign post_frame_vsync = sync_d2.vsync;
  assign post_frame_href  = sync_d2.href;
  assign post_frame_clken = sync_d2.clken;

  assign p11 = win[0][0];
  assign p12 = win[0][1];
  assign p13 = win[0][2];
  assign p21 = win[1][0];
  assign p22 = win[1][1];
  assign p23 = win[1][2];
  assign p31 = win[2][0];
  assign p32 = win[2][1];
  assign p33 = win[2][2];

endmodule

// File: tb/tb_vip_matrix_3x3_8bit.sv
`timescale 1ns/1ps
// Directed bench: 4x3 frames of pixel = 16*row+col through a replicate and a
// zero-border instance, plus a 640-wide instance for counter saturation.
module tb_vip_matrix_3x3_8bit;

  logic       clock;
  logic       rst_n;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_y;
  logic [7:0] lb_taps0x;
  logic [7:0] lb_taps1x;

  wire [71:0] win_rep, win_zero, win_big;
  wire [2:0]  post_rep, post_zero, post_big;
  wire        lbc_rep, lbh_rep, lbc_zero, lbh_zero, lbc_big, lbh_big;
  wire [7:0]  lbs_rep, lbs_zero, lbs_big;

  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  int         cyc      = 0;
  logic [71:0] snap_rep  [0:1023];
  logic [71:0] snap_zero [0:1023];
  logic [2:0]  snap_post [0:1023];
  int         issue [0:3][0:3];
  int         gap   [0:3];
  logic [2:0] in_hist1, in_hist2;
  logic       prev_ck;
  logic [7:0] tap0_pend, tap1_pend;

  vip_matrix_3x3_8bit #(.IMG_HDISP(4), .IMG_VDISP(3), .BORDER_MODE(1)) dut_rep (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .lb_clken(lbc_rep), .lb_href(lbh_rep), .lb_shiftin(lbs_rep),
    .lb_taps0x(lb_taps0x), .lb_taps1x(lb_taps1x),
    .post_frame_vsync(post_rep[2]), .post_frame_href(post_rep[1]), .post_frame_clken(post_rep[0]),
    .p11(win_rep[71:64]), .p12(win_rep[63:56]), .p13(win_rep[55:48]),
    .p21(win_rep[47:40]), .p22(win_rep[39:32]), .p23(win_rep[31:24]),
    .p31(win_rep[23:16]), .p32(win_rep[15:8]),  .p33(win_rep[7:0])
  );

  vip_matrix_3x3_8bit #(.IMG_HDISP(4), .IMG_VDISP(3), .BORDER_MODE(0)) dut_zero (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .lb_clken(lbc_zero), .lb_href(lbh_zero), .lb_shiftin(lbs_zero),
    .lb_taps0x(lb_taps0x), .lb_taps1x(lb_taps1x),
    .post_frame_vsync(post_zero[2]), .post_frame_href(post_zero[1]), .post_frame_clken(post_zero[0]),
    .p11(win_zero[71:64]), .p12(win_zero[63:56]), .p13(win_zero[55:48]),
    .p21(win_zero[47:40]), .p22(win_zero[39:32]), .p23(win_zero[31:24]),
    .p31(win_zero[23:16]), .p32(win_zero[15:8]),  .p33(win_zero[7:0])
  );

  vip_matrix_3x3_8bit #(.IMG_HDISP(640), .IMG_VDISP(480), .BORDER_MODE(1)) dut_big (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .lb_clken(lbc_big), .lb_href(lbh_big), .lb_shiftin(lbs_big),
    .lb_taps0x(lb_taps0x), .lb_taps1x(lb_taps1x),
    .post_frame_vsync(post_big[2]), .post_frame_href(post_big[1]), .post_frame_clken(post_big[0]),
    .p11(win_big[71:64]), .p12(win_big[63:56]), .p13(win_big[55:48]),
    .p21(win_big[47:40]), .p22(win_big[39:32]), .p23(win_big[31:24]),
    .p31(win_big[23:16]), .p32(win_big[15:8]),  .p33(win_big[7:0])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs after the edge, line-buffer taps for the previous
  // enabled pixel, then sample and check sync delay and pass-through.
  task automatic step(input logic vs, input logic hr, input logic ck, input int r, input int c);
    @(posedge clock);
    #1;
    if (prev_ck) begin
      lb_taps0x = tap0_pend;
      lb_taps1x = tap1_pend;
    end
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_y       = pix(r, c);
    prev_ck   = ck;
    tap0_pend = (r >= 1) ? pix(r - 1, c) : 8'h00;
    tap1_pend = (r >= 2) ? pix(r - 2, c) : 8'h00;
    @(negedge clock);
    cyc++;
    if (cyc < 1024) begin
      snap_rep[cyc]  = win_rep;
      snap_zero[cyc] = win_zero;
      snap_post[cyc] = post_rep;
    end
    chk("sync_delay_rep", 72'(post_rep), 72'(in_hist2));
    chk("sync_delay_big", 72'(post_big), 72'(in_hist2));
    chk("lb_pass", 72'({lbc_rep, lbh_rep, lbs_rep}), 72'({ck, hr, pix(r, c)}));
    in_hist2 = in_hist1;
    in_hist1 = {vs, hr, ck};
  endtask

  task automatic vsync_preamble();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_frame(input int rows, input int cols, input bit gaps);
    vsync_preamble();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        step(1'b0, 1'b1, 1'b1, r, c);
        issue[r][c] = cyc;
        if (gaps && (c < cols - 1)) begin
          step(1'b0, 1'b1, 1'b0, r, c);
          gap[c] = cyc;
        end
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y = 8'h00;
    lb_taps0x = 8'h00;
    lb_taps1x = 8'h00;
    in_hist1 = 3'b000;
    in_hist2 = 3'b000;
    prev_ck = 1'b0;
    tap0_pend = 8'h00;
    tap1_pend = 8'h00;

    // Reset state
    #3;
    chk("rst_win_rep", win_rep, 72'h0);
    chk("rst_win_zero", win_zero, 72'h0);
    chk("rst_post_rep", 72'(post_rep), 72'h0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
    #2 rst_n = 1'b1;

    // Frame 1: full 4x3 frame, both border modes
    run_frame(3, 4, 1'b0);
    chk("rep_r2c2",  snap_rep[issue[2][2] + 2],  72'h00_01_02_10_11_12_20_21_22);
    chk("rep_r0c0",  snap_rep[issue[0][0] + 2],  72'h00_00_00_00_00_00_00_00_00);
    chk("rep_r2c0",  snap_rep[issue[2][0] + 2],  72'h00_00_00_10_10_10_20_20_20);
    chk("rep_r1c3",  snap_rep[issue[1][3] + 2],  72'h01_02_03_01_02_03_11_12_13);
    chk("zero_r1c1", snap_zero[issue[1][1] + 2], 72'h00_00_00_00_00_01_00_10_11);
    chk("zero_r0c2", snap_zero[issue[0][2] + 2], 72'h00_00_00_00_00_00_00_01_02);
    chk("zero_r2c1", snap_zero[issue[2][1] + 2], 72'h00_00_01_00_10_11_00_20_21);
    chk("zero_r2c3", snap_zero[issue[2][3] + 2], 72'h01_02_03_11_12_13_21_22_23);
    chk("clken_r2c2", 72'(snap_post[issue[2][2] + 2]), 72'(3'b011));

    // Frame 2: one line with clken toggling inside href
    run_frame(1, 4, 1'b1);
    chk("tog_c1_win",  snap_rep[issue[0][1] + 2], 72'h00_00_01_00_00_01_00_00_01);
    chk("tog_c1_ck",   72'(snap_post[issue[0][1] + 2]), 72'(3'b011));
    chk("tog_gap0_ck", 72'(snap_post[gap[0] + 2]), 72'(3'b010));
    chk("tog_gap1_ck", 72'(snap_post[gap[1] + 2]), 72'(3'b010));
    chk("tog_gap2_ck", 72'(snap_post[gap[2] + 2]), 72'(3'b010));
    chk("tog_gap1_hold", snap_rep[gap[1] + 2], 72'h00_00_01_00_00_01_00_00_01);
    chk("tog_c3_win",  snap_rep[issue[0][3] + 2], 72'h01_02_03_01_02_03_01_02_03);

    // Frame 3: reset pulsed in the middle of line 1
    vsync_preamble();
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b1, 0, c);
    repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1, 0);
    step(1'b0, 1'b1, 1'b1, 1, 1);
    step(1'b0, 1'b1, 1'b0, 1, 1);
    chk("pre_rst_win", win_rep, 72'h00_00_00_00_00_00_10_10_10);
    chk("pre_rst_post", 72'(post_rep), 72'(3'b011));
    #2;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y = 8'h00;
    prev_ck = 1'b0;
    in_hist1 = 3'b000;
    in_hist2 = 3'b000;
    #1;
    chk("async_rst_win_rep",  win_rep, 72'h0);
    chk("async_rst_win_zero", win_zero, 72'h0);
    chk("async_rst_post_rep", 72'(post_rep), 72'h0);
    chk("async_rst_post_big", 72'(post_big), 72'h0);
    chk("async_rst_row_cnt",  72'(dut_rep.row_cnt), 72'h0);
    chk("async_rst_col_cnt",  72'(dut_rep.col_cnt), 72'h0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
    #2 rst_n = 1'b1;

    // Frame 4: normal frame after the reset
    run_frame(3, 4, 1'b0);
    chk("post_rst_r0c0",  snap_rep[issue[0][0] + 2],  72'h00_00_00_00_00_00_00_00_00);
    chk("post_rst_r0c1",  snap_rep[issue[0][1] + 2],  72'h00_00_01_00_00_01_00_00_01);
    chk("post_rst_r2c2",  snap_rep[issue[2][2] + 2],  72'h00_01_02_10_11_12_20_21_22);
    chk("post_rst_z_r1c1", snap_zero[issue[1][1] + 2], 72'h00_00_00_00_00_01_00_10_11);

    // Frame 5: one constant 640-pixel line for counter saturation
    vsync_preamble();
    for (int c = 0; c < 640; c++) step(1'b0, 1'b1, 1'b1, 0, c);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    chk("col_sat_big",   72'(dut_big.col_cnt), 72'd639);
    chk("col_sat_small", 72'(dut_rep.col_cnt), 72'd3);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    chk("col_clear_big", 72'(dut_big.col_cnt), 72'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vip_matrix_3x3_8bit.md
VIP_MATRIX_3X3_8BIT -- requirements
Module: vip_matrix_3x3_8bit

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameter BORDER_MODE, default 1, selecting the border fill: 1 = replicate, 0 = zero.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports per_frame_vsync, per_frame_href and per_frame_clken, input, 1 each, upstream frame sync, line valid and pixel enable.
REQ-007 SHALL have port per_img_y, input, 8, upstream pixel.
REQ-008 SHALL have ports lb_clken, lb_href and lb_shiftin, output, 1/1/8, driving the two-line buffer.
REQ-009 SHALL have ports lb_taps0x and lb_taps1x, input, 8 each, previous line and line-before-previous from the line buffer; each is valid 1 cycle after lb_clken.
REQ-010 SHALL have ports post_frame_vsync, post_frame_href and post_frame_clken, output, 1 each, sync signals aligned to the window.
REQ-011 SHALL have ports p11..p33, output, 8 each, the 3x3 window; row 1 is the oldest line, column 1 the oldest pixel, and p33 is the current pixel.

Function
REQ-012 SHALL drive lb_clken, lb_href and lb_shiftin combinationally from per_frame_clken, per_frame_href and per_img_y (zero-latency pass-through).
REQ-013 SHALL delay vsync, href and clken by exactly 2 cycles to form the post_ signals.
REQ-014 Stage 1 (register at t+1 for a clken at t) SHALL capture per_img_y delayed 1 cycle, lb_taps0x, lb_taps1x, col_cnt and row_cnt.
REQ-015 Stage 2 (register at t+2) SHALL shift the three row shift registers one column when stage-1 clken=1, then apply border substitution into p11..p33.
REQ-016 col_cnt SHALL count clken pulses within a line, clear while href=0, and saturate at IMG_HDISP-1.
REQ-017 row_cnt SHALL increment on each href falling edge, clear on the vsync rising edge, and saturate at IMG_VDISP-1.
REQ-018 Row border at row_cnt=0: rows 1 and 2 SHALL take row 3 (replicate) or 0 (zero mode).
REQ-019 Row border at row_cnt=1: row 1 SHALL take row 2 (replicate) or 0.
REQ-020 Column border at col_cnt=0: columns 1 and 2 SHALL take column 3 (replicate) or 0.
REQ-021 Column border at col_cnt=1: column 1 SHALL take column 2 (replicate) or 0.
REQ-022 Simultaneous row and column border SHALL apply the column rule first, then the row rule to the column-filled rows.
REQ-023 While clken=0 inside href, the window SHALL hold and post_frame_clken SHALL be 0.
REQ-024 p11..p33 SHALL be meaningful only when post_frame_clken=1, and SHALL hold their last values otherwise.
REQ-025 A vsync rising edge mid-line SHALL clear row_cnt and col_cnt without flushing the 2-cycle sync pipeline.
REQ-026 The counter width SHALL be clog2(IMG_HDISP) for col_cnt and clog2(IMG_VDISP) for row_cnt; all pixel arithmetic is unsigned 8-bit with no widening.

Reset
REQ-027 rst_n=0 SHALL immediately clear all post_ signals, p11..p33, both counters, all pipeline and delay registers, and the shift registers to 0.
REQ-028 After reset release, the first output SHALL appear 2 cycles after the first per_frame_clken.
REQ-029 Reset asserted mid-frame SHALL leave the block awaiting the next vsync rising edge with row_cnt=0.

Structure
REQ-030 The shared VIP package SHALL hold PIX_W=8, the BORDER_REPLICATE/BORDER_ZERO constants and a clog2 function.
REQ-031 One sub-module, vip_win_row_shift3 (a 3-tap 8-bit shift register with enable and async reset), SHALL be instantiated once per window row; the line buffer stays external.

Verification
REQ-032 4x3 frame with pixel = 16*row+col, BORDER_MODE=1 -> at row 2, col 2: p11..p33 = 00,01,02,10,11,12,20,21,22.
REQ-033 Same frame, BORDER_MODE=1, row 0, col 0 -> all nine outputs = 00.
REQ-034 Same frame, BORDER_MODE=0, row 1, col 1 -> p11,p12,p13,p21,p31 = 0; p22=00, p23=01, p32=10, p33=11.
REQ-035 clken toggled 1/0 within href -> post_frame_clken follows the same pattern delayed 2 cycles, and the window holds during the 0 cycles.
REQ-036 rst_n pulsed low mid-line 1 of a frame -> all outputs are 0 asynchronously; the next frame at row 0 matches REQ-033.
REQ-037 Constant stream with IMG_HDISP=640 -> post_frame_href matches per_frame_href delayed 2 cycles, and col_cnt reaches exactly 639 per line.
